mem_arbiter: RTL and testbench

- Single-port memory arbiter. It is the responder on the same request/hit handshake whose `dhit`/`ihit` the pipeline hazard logic consumes.
- Accepts instruction-fetch and data (LW/SW) requests from the datapath and serialises them onto one RAM port.
- Returns one-cycle `ihit`/`dhit` pulses with read data.
- Sits between the pipelined datapath and RAM.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// =============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter that serialises instruction-fetch and
//               data requests onto one RAM port. Compile with ARB_STALL_CNT_EN to
//               add the saturating stall counters.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic [CNT_W-1:0]  dstall_cnt,
  output logic [CNT_W-1:0]  istall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DACC = 2'd1,
    S_IACC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  logic   r_last_d;   // 1 when the most recent grant went to the data side

  logic w_dreq;
  logic w_grant_d;

  assign w_dreq    = dREN | dWEN;
  // On contention the side that was not served last wins.
  assign w_grant_d = w_dreq & (~iREN | ~r_last_d);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state  <= S_DACC;
            r_last_d <= 1'b1;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
          end else if (iREN) begin
            r_state  <= S_IACC;
            r_last_d <= 1'b0;
            ramaddr  <= iaddr;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
          end
        end
        S_DACC: begin
          if (ramready) begin
            if (!ramWEN) begin
              dload <= ramload;
            end
            // A withdrawn request finishes on the RAM side but is not acknowledged.
            dhit    <= w_dreq;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            r_state <= S_RESP;
          end
        end
        S_IACC: begin
          if (ramready) begin
            iload   <= ramload;
            ihit    <= iREN;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STALL_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_icnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dcnt <= '0;
      r_icnt <= '0;
    end else begin
      if (w_dreq && !dhit && (r_dcnt != '1)) begin
        r_dcnt <= r_dcnt + c_cnt_one;
      end
      if (iREN && !ihit && (r_icnt != '1)) begin
        r_icnt <= r_icnt + c_cnt_one;
      end
    end
  end

  assign dstall_cnt = r_dcnt;
  assign istall_cnt = r_icnt;
`else
  assign dstall_cnt = '0;
  assign istall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// =============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               variable-latency RAM responder.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  logic              CLK;
  logic              RST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;
  logic [CNT_W-1:0]  dstall_cnt;
  logic [CNT_W-1:0]  istall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int wait_cfg = 0;
  int ram_cnt  = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .ihit      (ihit),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dhit      (dhit),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramready  (ramready),
    .dstall_cnt(dstall_cnt),
    .istall_cnt(istall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM answers after wait_cfg strobe cycles; ready is driven on the falling edge.
  initial begin
    ramready = 1'b0;
    forever begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        ram_cnt  = ram_cnt + 1;
        ramready = (ram_cnt > wait_cfg);
      end else begin
        ram_cnt  = 0;
        ramready = 1'b0;
      end
    end
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_reset;
    step();
    n_checks++;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0000", {ihit, dhit, ramREN, ramWEN});
    end
    n_checks++;
    if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ram_bus: got addr=%h store=%h want 0/0", ramaddr, ramstore);
    end
    n_checks++;
    if (iload !== 32'h0 || dload !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_loads: got iload=%h dload=%h want 0/0", iload, dload);
    end
    n_checks++;
    if (dstall_cnt !== 3'd0 || istall_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got d=%0d i=%0d want 0/0", dstall_cnt, istall_cnt);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_zero_wait_fetch;
    wait_cfg = 0;
    ramload  = 32'h8C01_0004;
    iaddr    = 32'h40;
    iREN     = 1'b1;
    step();
    n_checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_strobe: got ren=%b wen=%b addr=%h ihit=%b want 1/0/00000040/0",
               ramREN, ramWEN, ramaddr, ihit);
    end
    step();
    n_checks++;
    if (ihit !== 1'b1 || iload !== 32'h8C01_0004 || dhit !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_hit: got ihit=%b iload=%h dhit=%b want 1/8c010004/0", ihit, iload, dhit);
    end
    iREN = 1'b0;
    step();
    n_checks++;
    if (ihit !== 1'b0 || ramREN !== 1'b0 || iload !== 32'h8C01_0004) begin
      n_fail++;
      $display("FAIL fetch_hit_end: got ihit=%b ren=%b iload=%h want 0/0/8c010004", ihit, ramREN, iload);
    end
    step();
  endtask

  task automatic test_arbitration;
    int dcyc = -1;
    int icyc = -1;
    int overlap = 0;
    int first_d = 0;
    do_reset();
    wait_cfg = 2;
    ramload  = 32'h1234_5678;
    iaddr    = 32'h44;
    daddr    = 32'h20;
    iREN     = 1'b1;
    dREN     = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) first_d = (ramREN === 1'b1 && ramaddr === 32'h20);
      if (ihit === 1'b1 && dhit === 1'b1) overlap++;
      if (dhit === 1'b1) begin
        dcyc = c;
        dREN = 1'b0;
      end
      if (ihit === 1'b1) begin
        icyc = c;
        iREN = 1'b0;
      end
    end
    n_checks++;
    if (first_d != 1) begin
      n_fail++;
      $display("FAIL arb_first_grant: got data_first=%0d want 1", first_d);
    end
    n_checks++;
    if (dcyc != 4) begin
      n_fail++;
      $display("FAIL arb_dhit_cycle: got %0d want 4", dcyc);
    end
    // Data RESP at 4, IDLE grant at 5, three fetch cycles 6..8, hit at 9.
    n_checks++;
    if (icyc != 9) begin
      n_fail++;
      $display("FAIL arb_ihit_cycle: got %0d want 9", icyc);
    end
    n_checks++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL arb_overlap: got %0d want 0", overlap);
    end
  endtask

  task automatic test_store_wait;
    int wen_cyc = 0;
    int bad     = 0;
    int hits    = 0;
    wait_cfg = 5;
    daddr    = 32'h100;
    dstore   = 32'hDEAD_BEEF;
    dWEN     = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 2) daddr = 32'h200;
      if (ramWEN === 1'b1) begin
        wen_cyc++;
        if (ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) bad++;
      end
      if (ramREN === 1'b1) bad++;
      if (dhit === 1'b1) begin
        hits++;
        dWEN = 1'b0;
      end
    end
    n_checks++;
    if (wen_cyc != 6) begin
      n_fail++;
      $display("FAIL store_wen_len: got %0d want 6", wen_cyc);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL store_bus: got %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (hits != 1) begin
      n_fail++;
      $display("FAIL store_hits: got %0d want 1", hits);
    end
  endtask

  task automatic test_flush;
    int ihits = 0;
    int dhits = 0;
    int dgrant = -1;
    wait_cfg = 3;
    ramload  = 32'hCAFE_0001;
    iaddr    = 32'h80;
    iREN     = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 2) begin
        iREN  = 1'b0;
        dREN  = 1'b1;
        daddr = 32'h10;
      end
      if (ihit === 1'b1) ihits++;
      if (dgrant < 0 && ramREN === 1'b1 && ramaddr === 32'h10) dgrant = c;
      if (dhit === 1'b1) begin
        dhits++;
        dREN = 1'b0;
      end
    end
    n_checks++;
    if (ihits != 0) begin
      n_fail++;
      $display("FAIL flush_ihit: got %0d want 0", ihits);
    end
    n_checks++;
    if (dgrant != 7) begin
      n_fail++;
      $display("FAIL flush_dgrant_cycle: got %0d want 7", dgrant);
    end
    n_checks++;
    if (dhits != 1 || dload !== 32'hCAFE_0001) begin
      n_fail++;
      $display("FAIL flush_dhit: got hits=%0d dload=%h want 1/cafe0001", dhits, dload);
    end
  endtask

  task automatic test_reset_mid_access;
    int hits = 0;
    wait_cfg = 10;
    daddr    = 32'h30;
    dREN     = 1'b1;
    step();
    step();
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dhit !== 1'b0 || dload !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: got ren=%b addr=%h dhit=%b dload=%h want 0/0/0/0",
               ramREN, ramaddr, dhit, dload);
    end
    dREN = 1'b0;
    #1;
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (dhit === 1'b1 || ramREN === 1'b1) hits++;
    end
    n_checks++;
    if (hits != 0) begin
      n_fail++;
      $display("FAIL rst_after: got %0d active cycles want 0", hits);
    end
    wait_cfg = 0;
    dREN     = 1'b1;
    step();
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h30) begin
      n_fail++;
      $display("FAIL rst_idle_grant: got ren=%b addr=%h want 1/00000030", ramREN, ramaddr);
    end
    step();
    dREN = 1'b0;
    step();
    step();
  endtask

  task automatic test_stall_cnt;
    do_reset();
`ifdef ARB_STALL_CNT_EN
    wait_cfg = 3;
    dREN     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (dhit === 1'b1) dREN = 1'b0;
    end
    // One IDLE cycle plus four DACC cycles are counted.
    n_checks++;
    if (dstall_cnt !== 3'd5 || istall_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_dcnt: got d=%0d i=%0d want 5/0", dstall_cnt, istall_cnt);
    end
    wait_cfg = 100;
    iREN     = 1'b1;
    for (int c = 0; c < 12; c++) step();
    n_checks++;
    if (istall_cnt !== 3'd7) begin
      n_fail++;
      $display("FAIL stall_isat: got %0d want 7", istall_cnt);
    end
    iREN = 1'b0;
    do_reset();
    n_checks++;
    if (istall_cnt !== 3'd0 || dstall_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_clear: got d=%0d i=%0d want 0/0", dstall_cnt, istall_cnt);
    end
`else
    wait_cfg = 3;
    dREN     = 1'b1;
    iREN     = 1'b1;
    for (int c = 0; c < 6; c++) step();
    n_checks++;
    if (dstall_cnt !== 3'd0 || istall_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_off: got d=%0d i=%0d want 0/0", dstall_cnt, istall_cnt);
    end
    dREN = 1'b0;
    iREN = 1'b0;
    do_reset();
`endif
  endtask

  initial begin
    RST     = 1'b1;
    iREN    = 1'b0;
    iaddr   = '0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    daddr   = '0;
    dstore  = '0;
    ramload = '0;
    test_reset();
    test_zero_wait_fetch();
    test_arbitration();
    test_store_wait();
    test_flush();
    test_reset_mid_access();
    test_stall_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
